scsp_dma_ctrl: RTL and testbench

Sequences SCSP DMA transfers between sound memory and the SCSP register/slot space. The CR5–CR7 fields (DMEA, DRGA, DTLG, DDIR, DGATE, DEXE) are the configuration; this block latches them and runs the word-by-word transfer. Each word is a memory handshake plus a register-space strobe. The block drives DEXE read-back and the DMA-end interrupt source (bit 4 of SCIPD/MCIPD). It sits between the SCSP register file, the sound-RAM arbiter and the interrupt logic.

---
 rtl/scsp_dma_ctrl.sv | 126 ++++++++++++
 tb/tb_scsp_dma_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scsp_dma_ctrl.sv
// SCSP DMA sequencer: moves DTLG words between sound memory and the SCSP
// register/slot space, one memory handshake plus one register strobe per word.
// The CR5-CR7 configuration is captured at start and held for the whole run.
module scsp_dma_ctrl #(
   parameter int MEM_AW = 19,
   parameter int REG_AW = 11,
   parameter int LEN_W  = 11
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CE,
   input  logic [MEM_AW-1:0] DMEA,
   input  logic [REG_AW-1:0] DRGA,
   input  logic [LEN_W-1:0]  DTLG,
   input  logic              DDIR,
   input  logic              DGATE,
   input  logic              DEXE_SET,
   output logic              BUSY,
   output logic              DONE_IRQ,
   output logic [MEM_AW-1:0] MEM_A,
   output logic [15:0]       MEM_DO,
   input  logic [15:0]       MEM_DI,
   output logic              MEM_RD,
   output logic              MEM_WR,
   input  logic              MEM_ACK,
   output logic [REG_AW-1:0] REG_A,
   output logic [15:0]       REG_DO,
   input  logic [15:0]       REG_DI,
   output logic              REG_RD,
   output logic              REG_WR
);

   typedef enum logic [2:0] {
      IDLE, MRD, RWR, RRD, RRD_W, MWR, DONE
   } state_t;

   state_t              state, state_nx;
   logic [MEM_AW-1:0]   mem_a;
   logic [REG_AW-1:0]   reg_a;
   logic [LEN_W-1:0]    cnt;
   logic [15:0]         data_q;
   logic                dir_q;
   logic                gate_q;
   logic                start;
   logic                word_done;

   // First state of a word: gated transfers skip the source-side read entirely.
   function automatic state_t first_state(input logic dir, input logic gate);
      if (dir) return gate ? MWR : RRD;
      else     return gate ? RWR : MRD;
   endfunction

   assign start = (state == IDLE) && DEXE_SET;

   // State register; reset wins over CE so an abort takes effect immediately.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state is updated with non-blocking assignments only,
      // so every register samples the pre-edge values of its neighbours.
      if (RST)     state <= IDLE;
      else if (CE) state <= state_nx;
   end

   // Next-state decode and word-completion detect.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave a value unassigned (no latches).
      state_nx  = state;
      word_done = 1'b0;
      unique case (state)
         IDLE:    if (DEXE_SET) state_nx = (DTLG == '0) ? DONE : first_state(DDIR, DGATE);
         MRD:     if (MEM_ACK)  state_nx = RWR;
         RWR:     word_done = 1'b1;
         RRD:     state_nx = RRD_W;
         RRD_W:   state_nx = MWR;
         MWR:     word_done = MEM_ACK;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (word_done)
         state_nx = (cnt == LEN_W'(1)) ? DONE : first_state(dir_q, gate_q);
   end

   // Datapath: configuration latch, data buffer, address and word counters.
   always_ff @(posedge CLK) begin
      // NOTE: the buffer and counters are reset explicitly because their
      // values are visible on MEM_DO/REG_DO/MEM_A/REG_A straight out of reset.
      if (RST) begin
         mem_a  <= '0;
         reg_a  <= '0;
         cnt    <= '0;
         data_q <= '0;
         dir_q  <= 1'b0;
         gate_q <= 1'b0;
      end else if (CE) begin
         if (start) begin
            mem_a  <= DMEA;
            reg_a  <= DRGA;
            cnt    <= DTLG;
            dir_q  <= DDIR;
            gate_q <= DGATE;
            // Cleared here so gated transfers write zeros without a mux.
            data_q <= '0;
         end
         if (state == MRD && MEM_ACK) data_q <= MEM_DI;
         if (state == RRD_W)          data_q <= REG_DI;
         if (word_done) begin
            mem_a <= mem_a + 1'b1;
            reg_a <= reg_a + 1'b1;
            cnt   <= cnt - 1'b1;
         end
      end
   end

   // Strobes and requests are pure state decodes, so CE=0 holds them as-is.
   assign BUSY     = (state != IDLE) && (state != DONE);
   assign DONE_IRQ = (state == DONE);
   assign MEM_RD   = (state == MRD);
   assign MEM_WR   = (state == MWR);
   assign REG_RD   = (state == RRD);
   assign REG_WR   = (state == RWR);
   assign MEM_A    = mem_a;
   assign REG_A    = reg_a;
   assign MEM_DO   = data_q;
   assign REG_DO   = data_q;

endmodule

// File: tb/tb_scsp_dma_ctrl.sv
// Directed bench for scsp_dma_ctrl with a memory responder (programmable ACK
// delay) and a register-space responder (data one cycle after REG_RD).
module tb_scsp_dma_ctrl;

   logic        CLK, RST, CE;
   logic [18:0] DMEA;
   logic [10:0] DRGA;
   logic [10:0] DTLG;
   logic        DDIR, DGATE, DEXE_SET;
   logic        BUSY, DONE_IRQ;
   logic [18:0] MEM_A;
   logic [15:0] MEM_DO, MEM_DI;
   logic        MEM_RD, MEM_WR, MEM_ACK;
   logic [10:0] REG_A;
   logic [15:0] REG_DO, REG_DI;
   logic        REG_RD, REG_WR;

   scsp_dma_ctrl dut (
      .CLK(CLK), .RST(RST), .CE(CE),
      .DMEA(DMEA), .DRGA(DRGA), .DTLG(DTLG), .DDIR(DDIR), .DGATE(DGATE),
      .DEXE_SET(DEXE_SET), .BUSY(BUSY), .DONE_IRQ(DONE_IRQ),
      .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_DI(MEM_DI),
      .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_ACK(MEM_ACK),
      .REG_A(REG_A), .REG_DO(REG_DO), .REG_DI(REG_DI),
      .REG_RD(REG_RD), .REG_WR(REG_WR)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Read data supplied by the memory and register responders, in order of use.
   logic [15:0] rd_tbl  [16];
   logic [15:0] reg_tbl [16];
   int ack_dly = 2;
   int mcnt = 0;
   int rd_idx = 0;
   int rg_idx = 0;
   logic reg_rd_q = 1'b0;

   // Memory responder: ACK after ack_dly cycles of a held request.
   always @(negedge CLK) begin
      if (MEM_ACK) begin
         MEM_ACK = 1'b0;
         mcnt = 0;
      end else if (MEM_RD || MEM_WR) begin
         mcnt++;
         if (mcnt >= ack_dly) begin
            MEM_ACK = 1'b1;
            if (MEM_RD) begin
               MEM_DI = rd_tbl[rd_idx];
               rd_idx++;
            end
         end
      end else begin
         mcnt = 0;
      end
   end

   // Register responder: data valid only in the cycle after a REG_RD.
   always @(posedge CLK) reg_rd_q <= REG_RD && CE && !RST;
   always @(negedge CLK) begin
      if (reg_rd_q) begin
         REG_DI = reg_tbl[rg_idx];
         rg_idx++;
      end else begin
         REG_DI = 16'hDEAD;
      end
   end

   // Bus monitor: logs every effective transaction with its cycle number.
   int cyc = 0;
   logic [10:0] rw_a [64];
   logic [15:0] rw_d [64];
   int          rw_c [64];
   logic [18:0] mr_a [64];
   logic [18:0] mw_a [64];
   logic [15:0] mw_d [64];
   logic [10:0] rr_a [64];
   int rw_n = 0, mr_n = 0, mw_n = 0, rr_n = 0;
   int irq_n = 0, irq_cyc = 0, mrd_cyc_n = 0, busy_irq_n = 0;

   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (CE && !RST) begin
         if (REG_WR) begin
            rw_a[rw_n] <= REG_A; rw_d[rw_n] <= REG_DO; rw_c[rw_n] <= cyc;
            rw_n <= rw_n + 1;
         end
         if (REG_RD) begin
            rr_a[rr_n] <= REG_A;
            rr_n <= rr_n + 1;
         end
         if (MEM_RD) mrd_cyc_n <= mrd_cyc_n + 1;
         if (MEM_RD && MEM_ACK) begin
            mr_a[mr_n] <= MEM_A;
            mr_n <= mr_n + 1;
         end
         if (MEM_WR && MEM_ACK) begin
            mw_a[mw_n] <= MEM_A; mw_d[mw_n] <= MEM_DO;
            mw_n <= mw_n + 1;
         end
         if (DONE_IRQ) begin
            irq_n <= irq_n + 1;
            irq_cyc <= cyc;
         end
         if (DONE_IRQ && BUSY) busy_irq_n <= busy_irq_n + 1;
      end
   end

   int st_cyc = 0;

   // Called at a negedge; the following posedge is the start cycle.
   task automatic start_dma(input logic [18:0] mea, input logic [10:0] rga,
                            input logic [10:0] tlg, input logic dir, input logic gate);
      DMEA = mea; DRGA = rga; DTLG = tlg; DDIR = dir; DGATE = gate;
      DEXE_SET = 1'b1;
      st_cyc = cyc;
      @(negedge CLK);
      DEXE_SET = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n0;
      int k;
      n0 = irq_n;
      k = 0;
      while (irq_n == n0 && k < budget) begin
         @(negedge CLK);
         k++;
      end
      check(tag, 32'(irq_n != n0), 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge CLK);
   endtask

   int b_rw, b_mr, b_mw, b_rr, b_irq, b_mrc;

   task automatic mark;
      b_rw = rw_n; b_mr = mr_n; b_mw = mw_n; b_rr = rr_n; b_irq = irq_n; b_mrc = mrd_cyc_n;
   endtask

   initial begin
      rd_tbl[0] = 16'h1111; rd_tbl[1] = 16'h2222; rd_tbl[2] = 16'h3333;
      rd_tbl[3] = 16'h4444; rd_tbl[4] = 16'h5555; rd_tbl[5] = 16'h6666;
      rd_tbl[6] = 16'h7777; rd_tbl[7] = 16'h8888;
      for (int i = 8; i < 16; i++) rd_tbl[i] = 16'hBAD0;
      reg_tbl[0] = 16'hA001; reg_tbl[1] = 16'hA002; reg_tbl[2] = 16'hA003;
      for (int i = 3; i < 16; i++) reg_tbl[i] = 16'hBAD1;

      RST = 1'b1; CE = 1'b1; DEXE_SET = 1'b0;
      DMEA = '0; DRGA = '0; DTLG = '0; DDIR = 1'b0; DGATE = 1'b0;
      MEM_ACK = 1'b0; MEM_DI = '0; REG_DI = '0;
      idle(3);

      // Reset state
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_irq", 32'(DONE_IRQ), 32'd0);
      check("rst_strobes", 32'({MEM_RD, MEM_WR, REG_RD, REG_WR}), 32'd0);
      check("rst_addr", 32'({MEM_A, REG_A}), 32'd0);
      check("rst_data", 32'({MEM_DO, REG_DO}), 32'd0);
      RST = 1'b0;
      idle(2);

      // mem->reg, ACK after 2 cycles
      mark();
      start_dma(19'h00100, 11'h010, 11'd3, 1'b0, 1'b0);
      check("m2r_busy_start1", 32'(BUSY), 32'd1);
      check("m2r_memrd_start1", 32'(MEM_RD), 32'd1);
      check("m2r_mema_start1", 32'(MEM_A), 32'h00100);
      wait_done("m2r_done", 60);
      check("m2r_busy_after", 32'(BUSY), 32'd0);
      idle(3);
      check("m2r_irq_once", 32'(irq_n - b_irq), 32'd1);
      check("m2r_busy_irq_overlap", 32'(busy_irq_n), 32'd0);
      check("m2r_nwr", 32'(rw_n - b_rw), 32'd3);
      check("m2r_wa0", 32'(rw_a[b_rw]),     32'h010);
      check("m2r_wd0", 32'(rw_d[b_rw]),     32'h1111);
      check("m2r_wa1", 32'(rw_a[b_rw + 1]), 32'h011);
      check("m2r_wd1", 32'(rw_d[b_rw + 1]), 32'h2222);
      check("m2r_wa2", 32'(rw_a[b_rw + 2]), 32'h012);
      check("m2r_wd2", 32'(rw_d[b_rw + 2]), 32'h3333);
      check("m2r_ra2", 32'(mr_a[b_mr + 2]), 32'h00102);

      // reg->mem with register address wrap, zero-wait ACK
      ack_dly = 1;
      mark();
      start_dma(19'h00200, 11'h7FE, 11'd3, 1'b1, 1'b0);
      wait_done("r2m_done", 60);
      check("r2m_cycles", 32'(irq_cyc - st_cyc), 32'd10);
      check("r2m_nrd", 32'(rr_n - b_rr), 32'd3);
      check("r2m_ra0", 32'(rr_a[b_rr]),     32'h7FE);
      check("r2m_ra1", 32'(rr_a[b_rr + 1]), 32'h7FF);
      check("r2m_ra2", 32'(rr_a[b_rr + 2]), 32'h000);
      check("r2m_nwr", 32'(mw_n - b_mw), 32'd3);
      check("r2m_ma0", 32'(mw_a[b_mw]),     32'h00200);
      check("r2m_md0", 32'(mw_d[b_mw]),     32'hA001);
      check("r2m_ma1", 32'(mw_a[b_mw + 1]), 32'h00201);
      check("r2m_md1", 32'(mw_d[b_mw + 1]), 32'hA002);
      check("r2m_ma2", 32'(mw_a[b_mw + 2]), 32'h00202);
      check("r2m_md2", 32'(mw_d[b_mw + 2]), 32'hA003);
      check("r2m_no_regwr", 32'(rw_n - b_rw), 32'd0);
      idle(2);

      // Gated mem->reg: 4 back-to-back zero writes, DONE 5 cycles after start
      ack_dly = 2;
      mark();
      start_dma(19'h00300, 11'h020, 11'd4, 1'b0, 1'b1);
      wait_done("gate_done", 30);
      check("gate_latency", 32'(irq_cyc - st_cyc), 32'd5);
      check("gate_no_memrd", 32'(mrd_cyc_n - b_mrc), 32'd0);
      check("gate_nwr", 32'(rw_n - b_rw), 32'd4);
      check("gate_wd0", 32'(rw_d[b_rw]),     32'h0000);
      check("gate_wd3", 32'(rw_d[b_rw + 3]), 32'h0000);
      check("gate_wa3", 32'(rw_a[b_rw + 3]), 32'h023);
      check("gate_consec", 32'(rw_c[b_rw + 3] - rw_c[b_rw]), 32'd3);
      idle(2);

      // DTLG=0: straight to DONE, no bus activity
      mark();
      start_dma(19'h00400, 11'h040, 11'd0, 1'b0, 1'b0);
      wait_done("len0_done", 10);
      check("len0_latency", 32'(irq_cyc - st_cyc), 32'd1);
      check("len0_no_bus", 32'((rw_n - b_rw) + (rr_n - b_rr) + (mw_n - b_mw) + (mrd_cyc_n - b_mrc)), 32'd0);
      idle(2);

      // Memory address wrap
      mark();
      start_dma(19'h7FFFF, 11'h100, 11'd2, 1'b0, 1'b0);
      wait_done("mwrap_done", 40);
      check("mwrap_ra0", 32'(mr_a[b_mr]),     32'h7FFFF);
      check("mwrap_ra1", 32'(mr_a[b_mr + 1]), 32'h00000);
      check("mwrap_wd1", 32'(rw_d[b_rw + 1]), 32'h5555);
      check("mwrap_wa1", 32'(rw_a[b_rw + 1]), 32'h101);
      idle(2);

      // DEXE_SET and input changes mid-transfer are ignored
      mark();
      start_dma(19'h00300, 11'h030, 11'd2, 1'b0, 1'b0);
      idle(1);
      DMEA = 19'h05000; DRGA = 11'h050; DTLG = 11'd5; DDIR = 1'b1; DGATE = 1'b1;
      DEXE_SET = 1'b1;
      idle(1);
      DEXE_SET = 1'b0;
      wait_done("ign_done", 40);
      idle(3);
      check("ign_irq_once", 32'(irq_n - b_irq), 32'd1);
      check("ign_nwr", 32'(rw_n - b_rw), 32'd2);
      check("ign_wa0", 32'(rw_a[b_rw]),     32'h030);
      check("ign_wd0", 32'(rw_d[b_rw]),     32'h6666);
      check("ign_wa1", 32'(rw_a[b_rw + 1]), 32'h031);
      check("ign_wd1", 32'(rw_d[b_rw + 1]), 32'h7777);
      check("ign_no_memwr", 32'(mw_n - b_mw), 32'd0);

      // Reset while MEM_RD is pending
      ack_dly = 10;
      mark();
      start_dma(19'h00400, 11'h070, 11'd2, 1'b0, 1'b0);
      idle(1);
      check("abort_pending", 32'(MEM_RD), 32'd1);
      RST = 1'b1;
      idle(1);
      RST = 1'b0;
      check("abort_strobes", 32'({MEM_RD, MEM_WR, REG_RD, REG_WR, BUSY, DONE_IRQ}), 32'd0);
      check("abort_addr", 32'({MEM_A, REG_A}), 32'd0);
      idle(15);
      check("abort_no_irq", 32'(irq_n - b_irq), 32'd0);
      check("abort_no_wr", 32'(rw_n - b_rw), 32'd0);
      ack_dly = 2;
      mark();
      start_dma(19'h00010, 11'h005, 11'd1, 1'b0, 1'b0);
      wait_done("post_abort_done", 20);
      check("post_abort_wa", 32'(rw_a[b_rw]), 32'h005);
      check("post_abort_wd", 32'(rw_d[b_rw]), 32'h8888);
      idle(2);

      // CE=0 freezes a held REG_WR
      mark();
      start_dma(19'h00500, 11'h060, 11'd2, 1'b0, 1'b1);
      CE = 1'b0;
      idle(3);
      check("ce_hold_wr", 32'(REG_WR), 32'd1);
      check("ce_hold_addr", 32'(REG_A), 32'h060);
      check("ce_no_effect", 32'(rw_n - b_rw), 32'd0);
      CE = 1'b1;
      wait_done("ce_done", 20);
      check("ce_nwr", 32'(rw_n - b_rw), 32'd2);
      check("ce_wa1", 32'(rw_a[b_rw + 1]), 32'h061);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
